// File: rtl/prog_timer_if.sv
// Control/status bundle of the programmable step timer.
// master: the block that programs the timer and consumes its status.
// slave : the timer itself.
interface prog_timer_if #(
    parameter int CNT_W = 8
);
    logic             counter_reset;
    logic             run;
    logic             mode;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] counter;
    logic             tick;
    logic             step;
    logic             wrap;
    logic             done;
    logic             capture_req;
    logic [CNT_W-1:0] capture_val;
    logic             capture_vld;

    modport master (
        output counter_reset, run, mode, limit, capture_req,
        input  counter, tick, step, wrap, done, capture_val, capture_vld
    );

    modport slave (
        input  counter_reset, run, mode, limit, capture_req,
        output counter, tick, step, wrap, done, capture_val, capture_vld
    );
endinterface

// File: rtl/prog_timer.sv
// Programmable step timer: prescaler -> sub-count -> step counter, all on one
// clock with single-cycle enable pulses (no derived clocks).
// Wrap (periodic) or one-shot mode against a programmable limit.
// Optional feature macro: CAPTURE_EN (counter snapshot on capture_req).
module prog_timer #(
    parameter int PRESCALE       = 5000000,
    parameter int TICKS_PER_STEP = 10,
    parameter int CNT_W          = 8
) (
    input  logic        clock,
    input  logic        reset,
    prog_timer_if.slave bus
);
    localparam int PRE_W = $clog2(PRESCALE);
    localparam int SUB_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_STEP - 1);

    logic [PRE_W-1:0] pre_cnt_r;
    logic [SUB_W-1:0] sub_cnt_r;
    logic [CNT_W-1:0] counter_r;
    logic             done_r;
    logic             tick_r;
    logic             step_r;
    logic             wrap_r;
    logic [CNT_W-1:0] capture_val_r;
    logic             capture_vld_r;

    logic             halted_s;
    logic             advance_s;
    logic             tick_evt_s;
    logic             step_evt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [PRE_W-1:0] pre_next_s;
    logic [SUB_W-1:0] sub_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             done_next_s;
    logic             tick_next_s;
    logic             step_next_s;
    logic             wrap_next_s;

    // Next-state of prescaler, sub-count, counter and status pulses.
    always_comb begin
        halted_s    = bus.mode & done_r;
        advance_s   = bus.run & ~halted_s;
        tick_evt_s  = advance_s & (pre_cnt_r == PRE_LAST);
        step_evt_s  = tick_evt_s & (sub_cnt_r == SUB_LAST);
        cnt_inc_s   = counter_r + CNT_W'(1);
        pre_next_s  = pre_cnt_r;
        sub_next_s  = sub_cnt_r;
        cnt_next_s  = counter_r;
        done_next_s = done_r;
        tick_next_s = 1'b0;
        step_next_s = 1'b0;
        wrap_next_s = 1'b0;
        if (bus.counter_reset) begin
            // Clear wins over a step due this cycle; that step is dropped.
            pre_next_s  = {PRE_W{1'b0}};
            sub_next_s  = {SUB_W{1'b0}};
            cnt_next_s  = {CNT_W{1'b0}};
            done_next_s = 1'b0;
        end else begin
            tick_next_s = tick_evt_s;
            step_next_s = step_evt_s;
            if (advance_s) begin
                pre_next_s = tick_evt_s ? {PRE_W{1'b0}} : pre_cnt_r + PRE_W'(1);
            end else begin
                pre_next_s = pre_cnt_r;
            end
            if (tick_evt_s) begin
                sub_next_s = step_evt_s ? {SUB_W{1'b0}} : sub_cnt_r + SUB_W'(1);
            end else begin
                sub_next_s = sub_cnt_r;
            end
            if (step_evt_s) begin
                if (!bus.mode) begin
                    // >= rather than == so a limit lowered below the count still wraps.
                    if (counter_r >= bus.limit) begin
                        cnt_next_s  = {CNT_W{1'b0}};
                        wrap_next_s = 1'b1;
                    end else begin
                        cnt_next_s = cnt_inc_s;
                    end
                end else begin
                    if (counter_r >= bus.limit) begin
                        cnt_next_s  = counter_r;
                        done_next_s = 1'b1;
                    end else if (cnt_inc_s == bus.limit) begin
                        cnt_next_s  = bus.limit;
                        done_next_s = 1'b1;
                    end else begin
                        cnt_next_s = cnt_inc_s;
                    end
                end
            end else begin
                cnt_next_s = counter_r;
            end
        end
    end

`ifndef CAPTURE_EN
    logic capture_unused_s;
    assign capture_unused_s = bus.capture_req;
`endif

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_cnt_r     <= {PRE_W{1'b0}};
            sub_cnt_r     <= {SUB_W{1'b0}};
            counter_r     <= {CNT_W{1'b0}};
            done_r        <= 1'b0;
            tick_r        <= 1'b0;
            step_r        <= 1'b0;
            wrap_r        <= 1'b0;
            capture_val_r <= {CNT_W{1'b0}};
            capture_vld_r <= 1'b0;
        end else begin
            pre_cnt_r <= pre_next_s;
            sub_cnt_r <= sub_next_s;
            counter_r <= cnt_next_s;
            done_r    <= done_next_s;
            tick_r    <= tick_next_s;
            step_r    <= step_next_s;
            wrap_r    <= wrap_next_s;
`ifdef CAPTURE_EN
            // Snapshot is the post-update value, so a clear in the same cycle captures 0.
            if (bus.capture_req) begin
                capture_val_r <= cnt_next_s;
                capture_vld_r <= 1'b1;
            end else begin
                capture_val_r <= capture_val_r;
                capture_vld_r <= 1'b0;
            end
`else
            capture_val_r <= {CNT_W{1'b0}};
            capture_vld_r <= 1'b0;
`endif
        end
    end

    assign bus.counter     = counter_r;
    assign bus.tick        = tick_r;
    assign bus.step        = step_r;
    assign bus.wrap        = wrap_r;
    assign bus.done        = done_r;
    assign bus.capture_val = capture_val_r;
    assign bus.capture_vld = capture_vld_r;
endmodule

// File: tb/tb_prog_timer.sv
// Bench for prog_timer with PRESCALE=4, TICKS_PER_STEP=2, CNT_W=3.
// Every expected step event (cycle, counter, wrap) is queued when stimulus is
// applied and compared when the DUT pulses step.
module tb_prog_timer;
    typedef struct {
        int         cyc;
        logic [2:0] cnt;
        logic       wrap;
    } exp_t;

`ifdef CAPTURE_EN
    localparam bit CAP_ON = 1'b1;
`else
    localparam bit CAP_ON = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   fails;
    int   cyc;
    exp_t sb_q[$];

    prog_timer_if #(.CNT_W(3)) bus ();

    prog_timer #(.PRESCALE(4), .TICKS_PER_STEP(2), .CNT_W(3)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Scoreboard: every step/wrap pulse must match the head of the queue.
    always @(posedge clock) begin
        exp_t e;
        cyc = cyc + 1;
        #2;
        if (bus.step === 1'b1) begin
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL sb_unexpected_step: got step at cycle %0d counter %0d, expected no step", cyc, bus.counter);
            end else begin
                e = sb_q.pop_front();
                if (cyc !== e.cyc || bus.counter !== e.cnt || bus.wrap !== e.wrap) begin
                    fails = fails + 1;
                    $display("FAIL sb_step: got cycle %0d counter %0d wrap %0b, expected cycle %0d counter %0d wrap %0b",
                             cyc, bus.counter, bus.wrap, e.cyc, e.cnt, e.wrap);
                end
            end
        end else if (bus.wrap !== 1'b0) begin
            checks = checks + 1;
            fails = fails + 1;
            $display("FAIL sb_wrap_no_step: got wrap %0b at cycle %0d, expected 0", bus.wrap, cyc);
        end
    end

    task automatic step_cycle();
        @(posedge clock);
        #3;
    endtask

    task automatic do_clear();
        bus.run           = 1'b0;
        bus.counter_reset = 1'b1;
        step_cycle();
        bus.counter_reset = 1'b0;
    endtask

    task automatic test_sb_empty(input string name);
        checks = checks + 1;
        if (sb_q.size() !== 0) begin
            fails = fails + 1;
            $display("FAIL %s_missing_steps: got %0d pending step events, expected 0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        bus.run           = 1'b1;
        bus.mode          = 1'b0;
        bus.limit         = 3'd7;
        bus.counter_reset = 1'b0;
        bus.capture_req   = 1'b0;
        repeat (3) begin
            step_cycle();
            checks = checks + 1;
            if ({bus.counter, bus.tick, bus.step, bus.wrap, bus.done, bus.capture_vld, bus.capture_val} !== 11'd0) begin
                fails = fails + 1;
                $display("FAIL reset_state: got counter %0d tick %0b step %0b wrap %0b done %0b vld %0b val %0d, expected all 0",
                         bus.counter, bus.tick, bus.step, bus.wrap, bus.done, bus.capture_vld, bus.capture_val);
            end
        end
        reset   = 1'b0;
        bus.run = 1'b0;
    endtask

    task automatic test_wrap();
        int e;
        logic [2:0] exp_c;
        logic exp_t_b;
        e = cyc;
        bus.mode  = 1'b0;
        bus.limit = 3'd7;
        bus.run   = 1'b1;
        for (int k = 1; k <= 8; k++)
            sb_q.push_back('{e + 8 * k, 3'(k % 8), (k == 8) ? 1'b1 : 1'b0});
        for (int j = 1; j <= 64; j++) begin
            step_cycle();
            exp_t_b = (j % 4 == 0) ? 1'b1 : 1'b0;
            exp_c   = 3'((j / 8) % 8);
            checks = checks + 1;
            if (bus.tick !== exp_t_b || bus.counter !== exp_c) begin
                fails = fails + 1;
                $display("FAIL wrap_tick_counter: at cycle %0d got tick %0b counter %0d, expected tick %0b counter %0d",
                         j, bus.tick, bus.counter, exp_t_b, exp_c);
            end
        end
        bus.run = 1'b0;
        step_cycle();
        test_sb_empty("wrap");
    endtask

    task automatic test_one_shot();
        int e;
        do_clear();
        e = cyc;
        bus.mode  = 1'b1;
        bus.limit = 3'd3;
        bus.run   = 1'b1;
        for (int k = 1; k <= 3; k++)
            sb_q.push_back('{e + 8 * k, 3'(k), 1'b0});
        for (int j = 1; j <= 24; j++) begin
            step_cycle();
            checks = checks + 1;
            if (bus.done !== ((j == 24) ? 1'b1 : 1'b0)) begin
                fails = fails + 1;
                $display("FAIL oneshot_done_time: at cycle %0d got done %0b, expected %0b", j, bus.done, (j == 24));
            end
        end
        checks = checks + 1;
        if (bus.counter !== 3'd3) begin
            fails = fails + 1;
            $display("FAIL oneshot_final: got counter %0d, expected 3", bus.counter);
        end
        for (int j = 1; j <= 40; j++) begin
            step_cycle();
            checks = checks + 1;
            if (bus.tick !== 1'b0 || bus.done !== 1'b1 || bus.counter !== 3'd3) begin
                fails = fails + 1;
                $display("FAIL oneshot_halted: at cycle %0d got tick %0b done %0b counter %0d, expected 0 1 3",
                         j, bus.tick, bus.done, bus.counter);
            end
        end
        bus.counter_reset = 1'b1;
        step_cycle();
        bus.counter_reset = 1'b0;
        e = cyc;
        checks = checks + 1;
        if (bus.counter !== 3'd0 || bus.done !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL oneshot_clear: got counter %0d done %0b, expected 0 0", bus.counter, bus.done);
        end
        sb_q.push_back('{e + 8, 3'd1, 1'b0});
        repeat (8) step_cycle();
        checks = checks + 1;
        if (bus.counter !== 3'd1 || bus.done !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL oneshot_restart: got counter %0d done %0b, expected 1 0", bus.counter, bus.done);
        end
        bus.run  = 1'b0;
        bus.mode = 1'b0;
        step_cycle();
        test_sb_empty("oneshot");
    endtask

    task automatic test_reset_on_step();
        int e;
        do_clear();
        e = cyc;
        bus.mode  = 1'b0;
        bus.limit = 3'd7;
        bus.run   = 1'b1;
        sb_q.push_back('{e + 8, 3'd1, 1'b0});
        repeat (15) step_cycle();
        bus.counter_reset = 1'b1;
        step_cycle();
        bus.counter_reset = 1'b0;
        checks = checks + 1;
        if (bus.step !== 1'b0 || bus.wrap !== 1'b0 || bus.counter !== 3'd0) begin
            fails = fails + 1;
            $display("FAIL clr_on_step: got step %0b wrap %0b counter %0d, expected 0 0 0", bus.step, bus.wrap, bus.counter);
        end
        sb_q.push_back('{e + 24, 3'd1, 1'b0});
        repeat (8) step_cycle();
        checks = checks + 1;
        if (bus.counter !== 3'd1 || bus.step !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL clr_next_step: got counter %0d step %0b, expected 1 1", bus.counter, bus.step);
        end
        bus.run = 1'b0;
        step_cycle();
        test_sb_empty("clr_on_step");
    endtask

    task automatic test_freeze();
        int e;
        do_clear();
        e = cyc;
        bus.mode  = 1'b0;
        bus.limit = 3'd7;
        bus.run   = 1'b1;
        sb_q.push_back('{e + 8, 3'd1, 1'b0});
        repeat (10) step_cycle();
        bus.run = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step_cycle();
            checks = checks + 1;
            if (bus.tick !== 1'b0 || bus.step !== 1'b0 || bus.counter !== 3'd1) begin
                fails = fails + 1;
                $display("FAIL freeze_hold: at cycle %0d got tick %0b step %0b counter %0d, expected 0 0 1",
                         j, bus.tick, bus.step, bus.counter);
            end
        end
        bus.run = 1'b1;
        step_cycle();
        checks = checks + 1;
        if (bus.tick !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL freeze_early_tick: got tick %0b, expected 0", bus.tick);
        end
        step_cycle();
        checks = checks + 1;
        if (bus.tick !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL freeze_resume_tick: got tick %0b, expected 1", bus.tick);
        end
        sb_q.push_back('{e + 26, 3'd2, 1'b0});
        repeat (4) step_cycle();
        checks = checks + 1;
        if (bus.counter !== 3'd2) begin
            fails = fails + 1;
            $display("FAIL freeze_resume_count: got counter %0d, expected 2", bus.counter);
        end
        bus.run = 1'b0;
        step_cycle();
        test_sb_empty("freeze");
    endtask

    task automatic test_limit_zero();
        int e;
        do_clear();
        e = cyc;
        bus.mode  = 1'b0;
        bus.limit = 3'd0;
        bus.run   = 1'b1;
        sb_q.push_back('{e + 8, 3'd0, 1'b1});
        sb_q.push_back('{e + 16, 3'd0, 1'b1});
        repeat (16) step_cycle();
        checks = checks + 1;
        if (bus.counter !== 3'd0 || bus.wrap !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL limit0: got counter %0d wrap %0b, expected 0 1", bus.counter, bus.wrap);
        end
        bus.run   = 1'b0;
        bus.limit = 3'd7;
        step_cycle();
        test_sb_empty("limit0");
    endtask

    task automatic test_capture();
        int e;
        logic [2:0] exp_v;
        do_clear();
        e = cyc;
        bus.mode  = 1'b0;
        bus.limit = 3'd7;
        bus.run   = 1'b1;
        for (int k = 1; k <= 5; k++)
            sb_q.push_back('{e + 8 * k, 3'(k), 1'b0});
        repeat (42) step_cycle();
        exp_v = CAP_ON ? 3'd5 : 3'd0;
        bus.capture_req = 1'b1;
        step_cycle();
        bus.capture_req = 1'b0;
        checks = checks + 1;
        if (bus.capture_val !== exp_v || bus.capture_vld !== CAP_ON) begin
            fails = fails + 1;
            $display("FAIL capture_5: got val %0d vld %0b, expected val %0d vld %0b",
                     bus.capture_val, bus.capture_vld, exp_v, CAP_ON);
        end
        step_cycle();
        checks = checks + 1;
        if (bus.capture_val !== exp_v || bus.capture_vld !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL capture_pulse: got val %0d vld %0b, expected val %0d vld 0",
                     bus.capture_val, bus.capture_vld, exp_v);
        end
        bus.capture_req   = 1'b1;
        bus.counter_reset = 1'b1;
        step_cycle();
        bus.capture_req   = 1'b0;
        bus.counter_reset = 1'b0;
        bus.run           = 1'b0;
        checks = checks + 1;
        if (bus.capture_val !== 3'd0 || bus.capture_vld !== CAP_ON || bus.counter !== 3'd0) begin
            fails = fails + 1;
            $display("FAIL capture_clr: got val %0d vld %0b counter %0d, expected 0 %0b 0",
                     bus.capture_val, bus.capture_vld, bus.counter, CAP_ON);
        end
        step_cycle();
        checks = checks + 1;
        if (bus.capture_vld !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL capture_vld_drop: got vld %0b, expected 0", bus.capture_vld);
        end
        test_sb_empty("capture");
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        cyc    = 0;
        test_reset();
        test_wrap();
        test_one_shot();
        test_reset_on_step();
        test_freeze();
        test_limit_zero();
        test_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
